// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared defaults and helpers for the block RAM primitives
package bram_pkg;

  // Default geometry: 2048 x 9 matches one 18 Kb device block RAM.
  localparam int DATA_W_DEF = 9;
  localparam int DEPTH_DEF  = 2048;
  localparam int ADDR_W_DEF = 11;

  // Ceiling log2, for instantiators that derive ADDR_W from DEPTH.
  // Returns 0 for inputs of 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_bram_if.sv
// rtl/sdp_bram_if.sv - bundled port A / port B signals of the dual-port RAM
interface sdp_bram_if #(
  parameter int DATA_W = bram_pkg::DATA_W_DEF,
  parameter int ADDR_W = bram_pkg::ADDR_W_DEF
);

  logic              ena;
  logic              enb;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dia;
  logic [DATA_W-1:0] dob;

  // The user of the RAM drives both address ports and receives read data.
  modport master (
    output ena, enb, wea, addra, addrb, dia,
    input  dob
  );

  // The RAM side of the same bundle.
  modport slave (
    input  ena, enb, wea, addra, addrb, dia,
    output dob
  );

endinterface

// File: rtl/sdp_bram_oreg.sv
// rtl/sdp_bram_oreg.sv - read data register with async clear and enable-gated load
module sdp_bram_oreg #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Capture the array output when the read port is enabled; reset clears at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sdp_bram.sv
// rtl/sdp_bram.sv - simple dual-port block RAM, one write port and one registered read port
module sdp_bram
  import bram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              enb,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] dob
);

  // Array index width; at least one bit so DEPTH=1 still has a legal index.
  localparam int IDX_W = (DEPTH > 1) ? int'(clog2(DEPTH)) : 1;

  // When the array fills the whole address space no address can be out of range.
  localparam bit FULL_MAP = (longint'(DEPTH) == (longint'(1) << ADDR_W));

  // Block RAM has no reset; the initialiser only gives simulation zeroed contents.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic              w_a_ok;
  logic              w_b_ok;
  logic              w_we;
  logic [IDX_W-1:0]  w_idxa;
  logic [IDX_W-1:0]  w_idxb;
  logic [DATA_W-1:0] w_rd;

  generate
    if (FULL_MAP) begin : g_full_map
      assign w_a_ok = 1'b1;
      assign w_b_ok = 1'b1;
    end else begin : g_part_map
      assign w_a_ok = ({1'b0, addra} < (ADDR_W + 1)'(DEPTH));
      assign w_b_ok = ({1'b0, addrb} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  assign w_idxa = addra[IDX_W-1:0];
  assign w_idxb = addrb[IDX_W-1:0];

  // Writes need both enables and an in-range address, and are blocked during reset.
  assign w_we = ena & wea & w_a_ok & ~rst;

  // Port A write; no reset term keeps this a clean block-RAM template.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idxa] <= dia;
    end
  end

  // Unmapped read addresses return zero. Sampling the array before the
  // write lands gives read-first behaviour on a same-address collision.
  assign w_rd = w_b_ok ? r_mem[w_idxb] : '0;

  sdp_bram_oreg #(
    .DATA_W(DATA_W)
  ) u_oreg (
    .clk   (clk),
    .rst   (rst),
    .i_load(enb),
    .i_d   (w_rd),
    .o_q   (dob)
  );

endmodule

// File: tb/tb_sdp_bram.sv
// tb/tb_sdp_bram.sv - self-checking bench for sdp_bram
module tb_sdp_bram;

  localparam int DW  = 9;
  localparam int AW  = 11;
  localparam int DEP = 2048;
  localparam int DEP_S = 1000;

  logic clk;
  logic rst;

  sdp_bram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  sdp_bram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

  sdp_bram #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (bus.ena),
    .enb  (bus.enb),
    .wea  (bus.wea),
    .addra(bus.addra),
    .addrb(bus.addrb),
    .dia  (bus.dia),
    .dob  (bus.dob)
  );

  sdp_bram #(DW, DEP_S, AW) u_dut_s (
    .clk  (clk),
    .rst  (rst),
    .ena  (bus_s.ena),
    .enb  (bus_s.enb),
    .wea  (bus_s.wea),
    .addra(bus_s.addra),
    .addrb(bus_s.addrb),
    .dia  (bus_s.dia),
    .dob  (bus_s.dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ena;
    logic          enb;
    logic          wea;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dia;
    int            exp;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  int checks = 0;
  int failures = 0;

  // Reference model: plain storage array plus the last read result.
  int unsigned model_mem [DEP];
  int unsigned model_dob;

  function automatic vec_t mk(input logic e_a, input logic e_b, input logic w,
                              input int a_a, input int a_b, input int d, input int x);
    vec_t v;
    v.ena   = e_a;
    v.enb   = e_b;
    v.wea   = w;
    v.addra = AW'(a_a);
    v.addrb = AW'(a_b);
    v.dia   = DW'(d);
    v.exp   = x;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model of one rising edge: reset wins, the read sees old contents, then the write lands.
  function automatic void model_edge();
    if (rst) begin
      model_dob = 0;
      return;
    end
    if (bus.enb) begin
      model_dob = (int'(bus.addrb) < DEP) ? model_mem[bus.addrb] : 0;
    end
    if (bus.ena && bus.wea && int'(bus.addra) < DEP) begin
      model_mem[bus.addra] = bus.dia;
    end
  endfunction

  task automatic apply(input vec_t v);
    bus.ena   = v.ena;
    bus.enb   = v.enb;
    bus.wea   = v.wea;
    bus.addra = v.addra;
    bus.addrb = v.addrb;
    bus.dia   = v.dia;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step_s(input logic e_a, input logic e_b, input logic w,
                        input int a_a, input int a_b, input int d);
    bus_s.ena   = e_a;
    bus_s.enb   = e_b;
    bus_s.wea   = w;
    bus_s.addra = AW'(a_a);
    bus_s.addrb = AW'(a_b);
    bus_s.dia   = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag, input vec_t q[$]);
    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      chk($sformatf("%s%0d_exp", tag, i), int'(bus.dob), q[i].exp);
      chk($sformatf("%s%0d_model", tag, i), int'(bus.dob), int'(model_dob));
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) model_mem[i] = 0;
    model_dob = 0;

    // Basic write/read, enable gating, read-first collision.
    //                ena enb wea addra addrb dia exp
    vecs_a.push_back(mk(1, 0, 1, 0, 0, 125, 0));
    vecs_a.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs_a.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs_a.push_back(mk(0, 1, 0, 0, 0, 0, 125));
    vecs_a.push_back(mk(0, 0, 0, 0, 0, 0, 125));
    vecs_a.push_back(mk(0, 0, 1, 5, 0, 300, 125));
    vecs_a.push_back(mk(0, 1, 0, 0, 5, 0, 0));
    vecs_a.push_back(mk(1, 0, 0, 5, 0, 300, 0));
    vecs_a.push_back(mk(0, 1, 0, 0, 5, 0, 0));
    vecs_a.push_back(mk(0, 1, 0, 0, 0, 0, 125));
    vecs_a.push_back(mk(0, 0, 0, 0, 5, 0, 125));
    vecs_a.push_back(mk(0, 0, 0, 0, 7, 0, 125));
    vecs_a.push_back(mk(1, 0, 1, 7, 0, 10, 125));
    vecs_a.push_back(mk(1, 1, 1, 7, 7, 20, 10));
    vecs_a.push_back(mk(0, 1, 0, 0, 7, 0, 20));
    vecs_a.push_back(mk(0, 1, 0, 0, 0, 0, 125));

    // Address extremes, then back-to-back streaming.
    vecs_b.push_back(mk(1, 0, 1, 2047, 0, 511, 125));
    vecs_b.push_back(mk(1, 0, 1, 0, 0, 1, 125));
    vecs_b.push_back(mk(0, 1, 0, 0, 2047, 0, 511));
    vecs_b.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int a = 0; a < 16; a++) vecs_b.push_back(mk(1, 0, 1, a, 0, a * 3, 1));
    for (int a = 0; a < 16; a++) vecs_b.push_back(mk(0, 1, 0, 0, a, 0, a * 3));

    bus.ena = 0; bus.enb = 0; bus.wea = 0;
    bus.addra = '0; bus.addrb = '0; bus.dia = '0;
    bus_s.ena = 0; bus_s.enb = 0; bus_s.wea = 0;
    bus_s.addra = '0; bus_s.addrb = '0; bus_s.dia = '0;

    rst = 1'b1;
    #1;
    chk("reset_dob", int'(bus.dob), 0);
    chk("reset_dob_s", int'(bus_s.dob), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    run_table("tblA_", vecs_a);

    // Asynchronous reset between edges, blocked write, retained contents.
    #3 rst = 1'b1;
    model_dob = 0;
    #1;
    chk("async_rst_clear", int'(bus.dob), 0);
    apply(mk(1, 0, 1, 0, 0, 77, 0));
    chk("rst_write_dob", int'(bus.dob), 0);
    apply(mk(0, 1, 0, 0, 0, 0, 0));
    chk("rst_read_held0", int'(bus.dob), 0);
    #3 rst = 1'b0;
    apply(mk(0, 1, 0, 0, 0, 0, 125));
    chk("post_rst_retain", int'(bus.dob), 125);
    chk("post_rst_model", int'(bus.dob), int'(model_dob));

    run_table("tblB_", vecs_b);

    // Partially mapped instance: out-of-range writes dropped, reads return zero.
    step_s(1, 0, 1, 1500, 0, 99);
    step_s(1, 0, 1, 999, 0, 55);
    step_s(1, 0, 1, 476, 0, 0);
    step_s(0, 1, 0, 0, 999, 0);
    chk("small_last_word", int'(bus_s.dob), 55);
    step_s(0, 1, 0, 0, 1500, 0);
    chk("small_oor_read", int'(bus_s.dob), 0);
    step_s(0, 1, 0, 0, 999, 0);
    step_s(0, 1, 0, 0, 1000, 0);
    chk("small_first_oor", int'(bus_s.dob), 0);
    step_s(0, 1, 0, 0, 476, 0);
    chk("small_no_alias", int'(bus_s.dob), 0);
    step_s(1, 0, 1, 1024 + 3, 0, 88);
    step_s(0, 1, 0, 0, 3, 0);
    chk("small_no_alias_lo", int'(bus_s.dob), 0);

    // Randomised traffic on a narrow address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      int sel;
      sel = int'($urandom_range(0, 7));
      v.ena   = 1'($urandom_range(0, 1));
      v.enb   = 1'($urandom_range(0, 1));
      v.wea   = 1'($urandom_range(0, 1));
      v.addra = (sel == 0) ? AW'($urandom_range(0, DEP - 1)) : AW'($urandom_range(0, 15));
      v.addrb = (sel == 1) ? AW'($urandom_range(0, DEP - 1)) : AW'($urandom_range(0, 15));
      v.dia   = DW'($urandom_range(0, (1 << DW) - 1));
      v.exp   = 0;
      apply(v);
      chk($sformatf("rand%0d", i), int'(bus.dob), int'(model_dob));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
